alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and result signals between alu_arbiter and its environment.
// slave = arbiter's view, master = requesters/ALU/consumer view.
interface alu_arbiter_if #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned FU_DATA_BITS  = 4 + 2 * XLEN
);
  logic                     req0_valid_i;
  logic                     req1_valid_i;
  logic                     req0_ready_o;
  logic                     req1_ready_o;
  logic [FU_DATA_BITS-1:0]  req0_data_i;
  logic [FU_DATA_BITS-1:0]  req1_data_i;
  logic [TRANS_ID_BITS-1:0] req0_trans_id_i;
  logic [TRANS_ID_BITS-1:0] req1_trans_id_i;
  logic [FU_DATA_BITS-1:0]  alu_data_o;
  logic [XLEN-1:0]          alu_result_i;
  logic                     alu_branch_res_i;
  logic                     res_valid_o;
  logic                     res_ready_i;
  logic [XLEN-1:0]          res_o;
  logic                     res_branch_o;
  logic                     res_port_o;
  logic [TRANS_ID_BITS-1:0] res_trans_id_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_data_i, req1_data_i,
    input  req0_trans_id_i, req1_trans_id_i,
    output req0_ready_o, req1_ready_o,
    output alu_data_o,
    input  alu_result_i, alu_branch_res_i,
    output res_valid_o, res_o, res_branch_o, res_port_o, res_trans_id_o,
    input  res_ready_i
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_data_i, req1_data_i,
    output req0_trans_id_i, req1_trans_id_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_data_o,
    output alu_result_i, alu_branch_res_i,
    input  res_valid_o, res_o, res_branch_o, res_port_o, res_trans_id_o,
    output res_ready_i
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a 2-entry in-order result buffer.
module alu_arbiter #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned FU_DATA_BITS  = 4 + 2 * XLEN
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  alu_arbiter_if.slave   bus
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic                     branch;
    logic                     port;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  entry_t fifo_q [2];
  logic [1:0] count_q;
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  port_e      last_grant_q;

  logic   can_accept;
  logic   gnt_valid;
  port_e  gnt_port;
  port_e  data_sel;
  logic   push;
  logic   pop;
  entry_t wr_entry;

  always_comb begin
    // A full buffer still accepts when its head is popped on the same edge.
    can_accept = rst_ni & ~flush_i &
                 ((count_q < 2'd2) | ((count_q == 2'd2) & bus.res_ready_i));

    gnt_port = PORT0;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      gnt_port = (last_grant_q == PORT0) ? PORT1 : PORT0;
    end else if (bus.req1_valid_i) begin
      gnt_port = PORT1;
    end
    gnt_valid = can_accept & (bus.req0_valid_i | bus.req1_valid_i);

    bus.req0_ready_o = gnt_valid & (gnt_port == PORT0);
    bus.req1_ready_o = gnt_valid & (gnt_port == PORT1);

    data_sel = PORT1;
    if (gnt_valid) begin
      data_sel = gnt_port;
    end else if (bus.req0_valid_i) begin
      data_sel = PORT0;
    end
    bus.alu_data_o = (data_sel == PORT0) ? bus.req0_data_i : bus.req1_data_i;

    push = gnt_valid;
    pop  = ~flush_i & (count_q != 2'd0) & bus.res_ready_i;

    wr_entry.result   = bus.alu_result_i;
    wr_entry.branch   = bus.alu_branch_res_i;
    wr_entry.port     = gnt_port;
    wr_entry.trans_id = (gnt_port == PORT0) ? bus.req0_trans_id_i : bus.req1_trans_id_i;

    bus.res_valid_o    = (count_q != 2'd0);
    bus.res_o          = fifo_q[rd_ptr_q].result;
    bus.res_branch_o   = fifo_q[rd_ptr_q].branch;
    bus.res_port_o     = fifo_q[rd_ptr_q].port;
    bus.res_trans_id_o = fifo_q[rd_ptr_q].trans_id;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      last_grant_q <= PORT1;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (flush_i) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q         <= ~wr_ptr_q;
        last_grant_q     <= gnt_port;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_alu_arbiter;

  localparam int unsigned TID = 3;
  localparam int unsigned XL  = 32;
  localparam int unsigned FUB = 4 + 2 * XL;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_EQ  = 4'd3;
  localparam logic [3:0] OP_LTU = 4'd4;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic flush_i = 1'b0;

  always #5 clk_i = ~clk_i;

  alu_arbiter_if #(.TRANS_ID_BITS(TID), .XLEN(XL), .FU_DATA_BITS(FUB)) bus ();

  alu_arbiter #(.TRANS_ID_BITS(TID), .XLEN(XL), .FU_DATA_BITS(FUB)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus)
  );

  function automatic logic [FUB-1:0] mk(logic [3:0] op, logic [XL-1:0] a, logic [XL-1:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [XL-1:0] ref_res(logic [FUB-1:0] d);
    logic [3:0]    op = d[FUB-1 -: 4];
    logic [XL-1:0] a  = d[2*XL-1 -: XL];
    logic [XL-1:0] b  = d[XL-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_EQ:   return {{(XL-1){1'b0}}, a == b};
      OP_LTU:  return {{(XL-1){1'b0}}, a < b};
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_br(logic [FUB-1:0] d);
    logic [3:0]    op = d[FUB-1 -: 4];
    logic [XL-1:0] a  = d[2*XL-1 -: XL];
    logic [XL-1:0] b  = d[XL-1:0];
    if (op == OP_EQ)  return a == b;
    if (op == OP_LTU) return a < b;
    return 1'b0;
  endfunction

  // The bench plays the shared ALU.
  always_comb begin
    bus.alu_result_i     = ref_res(bus.alu_data_o);
    bus.alu_branch_res_i = ref_br(bus.alu_data_o);
  end

  typedef struct {
    logic [XL-1:0]  res;
    logic           br;
    logic           port;
    logic [TID-1:0] id;
  } exp_t;

  exp_t q[$];
  logic last;
  int   total = 0;
  int   bad   = 0;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res_zero(string tag);
    check({tag, "_valid"},  bus.res_valid_o, 0);
    check({tag, "_res"},    bus.res_o, 0);
    check({tag, "_branch"}, bus.res_branch_o, 0);
    check({tag, "_port"},   bus.res_port_o, 0);
    check({tag, "_id"},     bus.res_trans_id_o, 0);
    check({tag, "_rdy0"},   bus.req0_ready_o, 0);
    check({tag, "_rdy1"},   bus.req1_ready_o, 0);
  endtask

  // One clock: compare outputs at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic v0, v1, acc, win, gnt;
    logic [FUB-1:0] wd;
    exp_t e;
    @(negedge clk_i);
    v0  = bus.req0_valid_i;
    v1  = bus.req1_valid_i;
    acc = rst_ni && !flush_i && (q.size() < 2 || bus.res_ready_i);
    win = (v0 && v1) ? ~last : ~v0;
    gnt = acc && (v0 || v1);
    check("ready0", bus.req0_ready_o, gnt && !win);
    check("ready1", bus.req1_ready_o, gnt && win);
    wd = (gnt ? win : ~v0) ? bus.req1_data_i : bus.req0_data_i;
    check("alu_data", bus.alu_data_o, wd);
    check("res_valid", bus.res_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      check("res_o", bus.res_o, q[0].res);
      check("res_branch", bus.res_branch_o, q[0].br);
      check("res_port", bus.res_port_o, q[0].port);
      check("res_id", bus.res_trans_id_o, q[0].id);
    end
    e.res  = ref_res(wd);
    e.br   = ref_br(wd);
    e.port = win;
    e.id   = win ? bus.req1_trans_id_i : bus.req0_trans_id_i;
    @(posedge clk_i);
    if (flush_i) begin
      q.delete();
    end else begin
      if (q.size() != 0 && bus.res_ready_i) q.delete(0);
      if (gnt) begin
        q.push_back(e);
        last = win;
      end
    end
    #1;
  endtask

  function automatic logic [FUB-1:0] rand_data();
    logic [XL-1:0] a = $urandom;
    logic [XL-1:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    return mk(4'($urandom_range(0, 4)), a, b);
  endfunction

  task automatic rand_ops();
    bus.req0_data_i     = rand_data();
    bus.req1_data_i     = rand_data();
    bus.req0_trans_id_i = TID'($urandom);
    bus.req1_trans_id_i = TID'($urandom);
  endtask

  initial begin
    last                = 1'b1;
    bus.req0_valid_i    = 1'b1;
    bus.req1_valid_i    = 1'b1;
    bus.res_ready_i     = 1'b0;
    rand_ops();

    // Reset state with both requesters valid.
    @(negedge clk_i);
    check_res_zero("reset");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // ADD 3+4 on port 0, SUB 9-2 on port 1.
    bus.req0_data_i = mk(OP_ADD, 3, 4); bus.req0_trans_id_i = 3'd1;
    bus.req1_data_i = mk(OP_SUB, 9, 2); bus.req1_trans_id_i = 3'd2;
    bus.res_ready_i = 1'b1;
    cycle();
    check("r035_res0", bus.res_o, 7);
    check("r035_port0", bus.res_port_o, 0);
    check("r035_id0", bus.res_trans_id_o, 1);
    cycle();
    check("r035_res1", bus.res_o, 7);
    check("r035_port1", bus.res_port_o, 1);
    check("r035_id1", bus.res_trans_id_o, 2);
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    cycle();

    // Continuous contention: alternating grants, no bubbles.
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      cycle();
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    cycle();

    // Backpressure: third op waits until the first pop.
    bus.res_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req0_data_i     = mk(OP_ADD, i, 10);
      bus.req0_trans_id_i = TID'(i);
      cycle();
    end
    check("r037_head_id", bus.res_trans_id_o, 0);
    bus.res_ready_i = 1'b1;
    cycle();
    bus.req0_valid_i = 1'b0;
    cycle();
    cycle();
    cycle();

    // Flush with a full buffer and both requesters valid.
    bus.res_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    rand_ops();
    cycle();
    rand_ops();
    cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check("r038_valid_after_flush", bus.res_valid_o, 0);
    cycle();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    bus.res_ready_i  = 1'b1;
    cycle();

    // EQ 5,5 on port 1 alone.
    bus.req1_valid_i    = 1'b1;
    bus.req1_data_i     = mk(OP_EQ, 5, 5);
    bus.req1_trans_id_i = 3'd5;
    cycle();
    check("r039_branch", bus.res_branch_o, 1);
    check("r039_port", bus.res_port_o, 1);
    bus.req1_valid_i = 1'b0;
    cycle();

    // Reset mid-operation with one buffered result.
    bus.res_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_data_i  = mk(OP_ADD, 32'h1234, 32'h1);
    bus.req0_trans_id_i = 3'd6;
    cycle();
    bus.req0_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1 check_res_zero("midreset");
    q.delete();
    last = 1'b1;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.res_ready_i  = 1'b1;
    rand_ops();
    cycle();
    check("r040_port0_wins", bus.res_port_o, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req0_valid_i = ($urandom_range(0, 3) != 0);
      bus.req1_valid_i = ($urandom_range(0, 3) != 0);
      bus.res_ready_i  = ($urandom_range(0, 2) != 0);
      flush_i          = ($urandom_range(0, 19) == 0);
      rand_ops();
      cycle();
    end
    flush_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
